// File: rtl/can_rx_deframer.sv
// can_rx_deframer
//   Receives one CAN-style frame at a time from the sampled bus level.
//   The receiver removes stuff bits, checks CRC-15 and the fixed-form bits,
//   drives the ACK slot, and presents the decoded fields once the frame is
//   complete.
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous active-low reset
//   bit_tick_i       one-cycle strobe at the bit sample point
//   rx_i             bus level (0 dominant, 1 recessive)
//   rx_busy          frame (or error recovery) in progress
//   ack_o            ACK drive, 0 = drive dominant
//   frame_valid_o    one-cycle pulse, good frame received
//   msg_type_o .. data_o   decoded fields, updated only with frame_valid_o
//   crc_err_o, stuff_err_o, form_err_o   one-cycle error pulses
module can_rx_deframer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bit_tick_i,
  input  logic        rx_i,
  output logic        rx_busy,
  output logic        ack_o,
  output logic        frame_valid_o,
  output logic        msg_type_o,
  output logic [5:0]  addr_sender_o,
  output logic [5:0]  addr_recipient_o,
  output logic [1:0]  sign_o,
  output logic [1:0]  attribute_o,
  output logic [3:0]  expand_count_o,
  output logic [7:0]  cmd_data_sign_o,
  output logic        rtr_o,
  output logic [3:0]  dlc_o,
  output logic [63:0] data_o,
  output logic        crc_err_o,
  output logic        stuff_err_o,
  output logic        form_err_o
);

  typedef enum logic [3:0] {
    IDLE, SOF, FIELDS, CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, ERR_WAIT
  } state_t;

  // Field index while in SOF/FIELDS
  localparam logic [3:0] F_MSG = 4'd0;
  localparam logic [3:0] F_SND = 4'd1;
  localparam logic [3:0] F_RHI = 4'd2;
  localparam logic [3:0] F_SRR = 4'd3;
  localparam logic [3:0] F_IDE = 4'd4;
  localparam logic [3:0] F_RLO = 4'd5;
  localparam logic [3:0] F_SGN = 4'd6;
  localparam logic [3:0] F_ATT = 4'd7;
  localparam logic [3:0] F_EXP = 4'd8;
  localparam logic [3:0] F_CMD = 4'd9;
  localparam logic [3:0] F_RTR = 4'd10;
  localparam logic [3:0] F_RSV = 4'd11;
  localparam logic [3:0] F_DLC = 4'd12;
  localparam logic [3:0] F_DAT = 4'd13;

  function automatic logic [6:0] fld_len(input logic [3:0] f);
    logic [6:0] len;
    case (f)
      F_MSG, F_SRR, F_IDE, F_RTR:        len = 7'd1;
      F_RLO, F_SGN, F_ATT, F_RSV:        len = 7'd2;
      F_RHI, F_EXP, F_DLC:               len = 7'd4;
      F_SND:                             len = 7'd6;
      F_CMD:                             len = 7'd8;
      F_DAT:                             len = 7'd64;
      default:                           len = 7'd1;
    endcase
    return len;
  endfunction

  function automatic logic [14:0] crc15_step(input logic [14:0] c, input logic b);
    logic [14:0] n;
    n = {c[13:0], 1'b0};
    if (b ^ c[14]) n = n ^ 15'h4599;
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  fld_q, fld_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  run_q, run_d;
  logic        last_q, last_d;
  logic        crc_ok_q, crc_ok_d;
  logic        ack_d, fv_d, crc_err_d, stuff_err_d, form_err_d;
  logic        take_bit, crc_bit, crc_clr, load_out;

  // Stored header bits, MSB-first: msg, sender, recip_hi, recip_lo, sign,
  // attribute, expand, cmd, dlc (SRR/IDE/reserved/RTR are not kept here).
  logic [32:0] hdr_q;
  logic [63:0] data_q;
  logic [13:0] rx_crc_q;
  logic [14:0] crc_q;
  logic        rtr_q;

  assign rx_busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    fld_d       = fld_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    last_d      = last_q;
    crc_ok_d    = crc_ok_q;
    ack_d       = ack_o;
    fv_d        = 1'b0;
    crc_err_d   = 1'b0;
    stuff_err_d = 1'b0;
    form_err_d  = 1'b0;
    take_bit    = 1'b0;
    crc_bit     = 1'b0;
    crc_clr     = 1'b0;
    load_out    = 1'b0;
    if (bit_tick_i) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_i) begin
            state_d = SOF;
            fld_d   = F_MSG;
            cnt_d   = '0;
            run_d   = 3'd1;      // SOF itself starts the dominant run
            last_d  = 1'b0;
            crc_clr = 1'b1;
          end
        end
        SOF, FIELDS, CRC: begin
          if (run_q == 3'd5) begin
            // Stuff bit slot: must be the opposite polarity, then dropped
            if (rx_i == last_q) begin
              stuff_err_d = 1'b1;
              state_d     = ERR_WAIT;
              cnt_d       = '0;
            end else begin
              run_d  = 3'd1;
              last_d = rx_i;
            end
          end else begin
            run_d  = (rx_i == last_q) ? run_q + 3'd1 : 3'd1;
            last_d = rx_i;
            if (state_q == CRC) begin
              crc_bit = 1'b1;
              if (cnt_q == 7'd14) begin
                state_d  = CRC_DELIM;
                cnt_d    = '0;
                crc_ok_d = ({rx_crc_q, rx_i} == crc_q);
              end else begin
                cnt_d = cnt_q + 7'd1;
              end
            end else begin
              take_bit = 1'b1;
              if ((fld_q == F_SRR || fld_q == F_IDE) && !rx_i) begin
                form_err_d = 1'b1;
                state_d    = ERR_WAIT;
                cnt_d      = '0;
              end else if (cnt_q == fld_len(fld_q) - 7'd1) begin
                cnt_d = '0;
                if (fld_q == F_DAT || (fld_q == F_DLC && rtr_q)) begin
                  state_d = CRC;
                end else begin
                  fld_d   = fld_q + 4'd1;
                  state_d = FIELDS;
                end
              end else begin
                cnt_d   = cnt_q + 7'd1;
                state_d = FIELDS;
              end
            end
          end
        end
        CRC_DELIM: begin
          cnt_d = '0;
          if (!crc_ok_q) begin
            crc_err_d = 1'b1;
            state_d   = ERR_WAIT;
          end else if (!rx_i) begin
            form_err_d = 1'b1;
            state_d    = ERR_WAIT;
          end else begin
            state_d = ACK_SLOT;
            ack_d   = 1'b0;
          end
        end
        ACK_SLOT: begin
          // Slot sample is ignored; release the dominant drive
          state_d = ACK_DELIM;
          ack_d   = 1'b1;
        end
        ACK_DELIM: begin
          cnt_d = '0;
          if (!rx_i) begin
            form_err_d = 1'b1;
            state_d    = ERR_WAIT;
          end else begin
            state_d = EOF;
          end
        end
        EOF: begin
          if (!rx_i) begin
            form_err_d = 1'b1;
            state_d    = ERR_WAIT;
            cnt_d      = '0;
          end else if (cnt_q == 7'd6) begin
            fv_d     = 1'b1;
            load_out = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        ERR_WAIT: begin
          if (!rx_i) begin
            cnt_d = '0;
          end else if (cnt_q == 7'd6) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      fld_q         <= '0;
      cnt_q         <= '0;
      run_q         <= 3'd1;
      last_q        <= 1'b1;
      crc_ok_q      <= 1'b0;
      ack_o         <= 1'b1;
      frame_valid_o <= 1'b0;
      crc_err_o     <= 1'b0;
      stuff_err_o   <= 1'b0;
      form_err_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fld_q         <= fld_d;
      cnt_q         <= cnt_d;
      run_q         <= run_d;
      last_q        <= last_d;
      crc_ok_q      <= crc_ok_d;
      ack_o         <= ack_d;
      frame_valid_o <= fv_d;
      crc_err_o     <= crc_err_d;
      stuff_err_o   <= stuff_err_d;
      form_err_o    <= form_err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hdr_q            <= '0;
      data_q           <= '0;
      rx_crc_q         <= '0;
      crc_q            <= '0;
      rtr_q            <= 1'b0;
      msg_type_o       <= 1'b0;
      addr_sender_o    <= '0;
      addr_recipient_o <= '0;
      sign_o           <= '0;
      attribute_o      <= '0;
      expand_count_o   <= '0;
      cmd_data_sign_o  <= '0;
      rtr_o            <= 1'b0;
      dlc_o            <= '0;
      data_o           <= '0;
    end else begin
      if (crc_clr) begin
        crc_q <= '0;
      end else if (take_bit) begin
        crc_q <= crc15_step(crc_q, rx_i);
      end
      if (take_bit) begin
        if (fld_q == F_DAT) begin
          data_q <= {data_q[62:0], rx_i};
        end else if (fld_q == F_RTR) begin
          rtr_q <= rx_i;
        end else if (fld_q != F_SRR && fld_q != F_IDE && fld_q != F_RSV) begin
          hdr_q <= {hdr_q[31:0], rx_i};
        end
      end
      if (crc_bit) begin
        rx_crc_q <= {rx_crc_q[12:0], rx_i};
      end
      if (load_out) begin
        msg_type_o       <= hdr_q[32];
        addr_sender_o    <= hdr_q[31:26];
        addr_recipient_o <= {hdr_q[25:22], hdr_q[21:20]};
        sign_o           <= hdr_q[19:18];
        attribute_o      <= hdr_q[17:16];
        expand_count_o   <= hdr_q[15:12];
        cmd_data_sign_o  <= hdr_q[11:4];
        dlc_o            <= hdr_q[3:0];
        rtr_o            <= rtr_q;
        // Data shift register may hold a previous frame's bits on RTR
        data_o           <= rtr_q ? 64'h0 : data_q;
      end
    end
  end

endmodule

// File: doc/can_rx_deframer.md
CAN_RX_DEFRAMER -- requirements
Module: can_rx_deframer

Interface
REQ-001 The module SHALL have one clock and one reset: the clock is clk_i, and the reset is rst_i, which is asynchronous and active-low.
REQ-002 Port list:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-low reset.
- bit_tick_i  in  1  one-clk_i-cycle strobe at the CAN bit sample point, from the baud generator.
- rx_i  in  1  CAN bus level (0 dominant, 1 recessive).
- rx_busy  out  1  frame in progress.
- ack_o  out  1  ACK drive, 0 = drive dominant.
- frame_valid_o  out  1  one-cycle pulse; a good frame has been received.
- msg_type_o  out  1  C/D bit.
- addr_sender_o  out  6  local address field.
- addr_recipient_o  out  6  remote address field.
- sign_o  out  2  handshaking/pointer field.
- attribute_o  out  2  attribute field.
- expand_count_o  out  4  expand/count field.
- cmd_data_sign_o  out  8  command/data sign.
- rtr_o  out  1  RTR bit.
- dlc_o  out  4  data length code.
- data_o  out  64  data field, first received bit in bit 63.
- crc_err_o, stuff_err_o, form_err_o  out  1 each  one-cycle error pulses.

Function
REQ-003 All bus activity SHALL be evaluated only in clk_i cycles where bit_tick_i=1; in all other cycles the state is held.
REQ-004 The FSM SHALL have these states: IDLE, SOF, FIELDS, CRC, CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF, ERR_WAIT.
REQ-005 In IDLE, a sampled rx_i=0 SHALL enter SOF and set rx_busy=1; a sampled rx_i=1 SHALL keep the FSM in IDLE.
REQ-006 Bits SHALL arrive MSB-first in this unstuffed order:
- SOF(0).
- msg_type (1).
- addr_sender (6).
- addr_recipient[5:2] (4).
- SRR (1).
- IDE (1).
- addr_recipient[1:0] (2).
- sign (2).
- attribute (2).
- expand_count (4).
- cmd_data_sign (8).
- RTR (1).
- reserved (2).
- DLC (4).
- data: 64 bits if RTR=0, 0 bits if RTR=1.
- CRC (15).
REQ-007 A 7-bit field counter SHALL index bits within each field and SHALL reset to 0 on every field change.
REQ-008 Destuffing SHALL run from SOF through the last CRC bit:
- After 5 consecutive equal sampled bits, the next sampled bit SHALL be discarded (not counted, not shifted into the CRC) and SHALL restart the run count at 1 with its own polarity.
- If that discarded bit equals the previous 5, stuff_err_o SHALL pulse and the FSM SHALL enter ERR_WAIT.
REQ-009 CRC-15 SHALL be computed over destuffed bits from msg_type through the last data bit, excluding SOF:
- Initial value 0.
- crc_next = bit XOR crc[14].
- crc = {crc[13:0],0}, XOR 15'h4599 when crc_next=1.
REQ-010 The 15 received CRC bits SHALL be compared with the computed CRC at the end of CRC.
REQ-011 SRR and IDE SHALL both be 1, and CRC_DELIM, ACK_DELIM and all 7 EOF bits SHALL be 1; any 0 in these positions SHALL pulse form_err_o and enter ERR_WAIT.
REQ-012 ACK handling:
- ack_o SHALL be 0 for exactly the ACK_SLOT bit time when the CRC matched, and 1 otherwise.
- ack_o SHALL be registered and SHALL change in the cycle after the bit_tick_i that enters or leaves ACK_SLOT.
- The ACK_SLOT sample value SHALL be ignored.
REQ-013 On a CRC mismatch, crc_err_o SHALL pulse at the CRC_DELIM tick, ack_o SHALL stay 1, and the FSM SHALL enter ERR_WAIT.
REQ-014 After the 7th EOF bit samples 1, in the same cycle:
- All field outputs SHALL update.
- frame_valid_o SHALL pulse for one clk_i cycle.
- rx_busy SHALL drop to 0 and the FSM SHALL return to IDLE.
REQ-015 Field outputs SHALL change only at frame_valid_o and SHALL hold their values between frames and across errors.
REQ-016 When RTR=1, data_o SHALL be loaded with 64'h0.
REQ-017 ERR_WAIT SHALL count consecutive sampled 1s; after 7, it SHALL return to IDLE with rx_busy=0. Any sampled 0 SHALL restart the count.
REQ-018 At most one error pulse SHALL be issued per frame.

Reset
REQ-019 While rst_i=0, regardless of bit_tick_i:
- FSM = IDLE and all counters = 0.
- CRC = 0 and stuff run count = 1.
- rx_busy=0 and ack_o=1.
- frame_valid_o, crc_err_o, stuff_err_o and form_err_o = 0.
- All field outputs = 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the block SHALL wait in IDLE for the next SOF.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Good frame, stuffed by the bench model: msg_type=0, sender=6'b000101, recipient=6'b100010, sign=2'b10, attribute=2'b10, expand=4'b1011, cmd=8'hF5, RTR=0, DLC=4'b1001, data=64'h3132333435363738, correct CRC -> ack_o=0 during the slot, one frame_valid_o pulse, all outputs equal the sent values.
- Same frame with one data bit flipped after CRC generation -> crc_err_o pulse, ack_o stays 1, outputs unchanged, FSM back in IDLE after 7 recessive bits.
- Six consecutive dominant bits inside addr_sender (stuff bit omitted) -> stuff_err_o pulse, no frame_valid_o.
- CRC delimiter driven 0 -> form_err_o pulse; a following good frame is still received correctly.
- RTR=1 frame with no data field, correct CRC -> frame_valid_o pulse, rtr_o=1, data_o=64'h0.
- rst_i pulsed low during the data field -> all outputs at reset values, no pulses; the next good frame is received correctly.
